// File: rtl/mp_addsub_seq.sv
// mp_addsub_seq: streams multi-word operands LSW first through the add_sub
// datapath. Each word is read in one cycle and computed and written in the
// next, so the carry or borrow chains through the add_sub carry register.
module mp_addsub_seq #(
  parameter int CP_D_WIDTH = 72,
  parameter int ADDR_W     = 8,
  parameter int LEN_W      = 8
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic [LEN_W-1:0]      len,
  input  logic [ADDR_W-1:0]     src0_addr,
  input  logic [ADDR_W-1:0]     src1_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  carry_out,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr0,
  output logic [ADDR_W-1:0]     rd_addr1,
  input  logic [CP_D_WIDTH-1:0] rd_data0,
  input  logic [CP_D_WIDTH-1:0] rd_data1,
  output logic [1:0]            ArithOp,
  output logic                  ArithRegOp,
  output logic [CP_D_WIDTH-1:0] IN_REG0,
  output logic [CP_D_WIDTH-1:0] IN_REG1,
  input  logic [CP_D_WIDTH-1:0] add_sub_out,
  input  logic                  add_sub_carry,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [CP_D_WIDTH-1:0] wr_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_CAPT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_idx;
  logic [LEN_W-1:0]    r_cmp_idx;
  logic                r_op_sub;
  logic [ADDR_W-1:0]   r_src0;
  logic [ADDR_W-1:0]   r_src1;
  logic [ADDR_W-1:0]   r_dst;
  logic                r_cmp_valid;
  logic                r_done;
  logic                r_carry;
  logic                w_accept;
  logic                w_last_rd;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_last_rd = (r_idx == r_len - LEN_W'(1));

  // State register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (len == '0) ? S_CAPT : S_RUN;
      S_RUN:   if (w_last_rd) w_next = S_FLUSH;
      S_FLUSH: w_next = S_CAPT;
      S_CAPT:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: read stage from the state, compute/write stage from the delayed read
  always_comb begin
    busy       = (r_state != S_IDLE);
    rd_en      = (r_state == S_RUN);
    rd_addr0   = rd_en ? r_src0 + ADDR_W'(r_idx) : '0;
    rd_addr1   = rd_en ? r_src1 + ADDR_W'(r_idx) : '0;
    wr_en      = r_cmp_valid;
    wr_addr    = r_cmp_valid ? r_dst + ADDR_W'(r_cmp_idx) : '0;
    wr_data    = add_sub_out;
    ArithOp    = r_cmp_valid ? {(r_cmp_idx != '0), ~r_op_sub} : 2'b00;
    ArithRegOp = 1'b0;
    IN_REG0    = rd_data0;
    IN_REG1    = rd_data1;
    done       = r_done;
    carry_out  = r_carry;
  end

  // Command capture on acceptance
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_len    <= '0;
      r_op_sub <= 1'b0;
      r_src0   <= '0;
      r_src1   <= '0;
      r_dst    <= '0;
    end else if (w_accept) begin
      r_len    <= len;
      r_op_sub <= op_sub;
      r_src0   <= src0_addr;
      r_src1   <= src1_addr;
      r_dst    <= dst_addr;
    end
  end

  // Word index for reads, and its one-cycle-delayed copy for the compute stage
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_idx       <= '0;
      r_cmp_idx   <= '0;
      r_cmp_valid <= 1'b0;
    end else begin
      if (w_accept)              r_idx <= '0;
      else if (r_state == S_RUN) r_idx <= r_idx + LEN_W'(1);
      r_cmp_idx   <= r_idx;
      r_cmp_valid <= (r_state == S_RUN);
    end
  end

  // Completion: carry register holds the last word's carry during CAPT
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_done  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_done <= (r_state == S_CAPT);
      if (r_state == S_CAPT) r_carry <= (r_len == '0) ? 1'b0 : add_sub_carry;
    end
  end

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Bench for mp_addsub_seq: models the operand memory and the add_sub unit,
// and predicts results with whole-number multi-precision arithmetic.
module tb_mp_addsub_seq;

  localparam int W    = 72;
  localparam int AW   = 8;
  localparam int LW   = 8;
  localparam int MAXL = 8;

  typedef struct {
    logic          op;
    int unsigned   len;
    logic [AW-1:0] s0;
    logic [AW-1:0] s1;
    logic [AW-1:0] d;
  } cmd_t;

  logic          clock = 1'b0;
  logic          nreset = 1'b0;
  logic          start = 1'b0;
  logic          op_sub = 1'b0;
  logic [LW-1:0] len = '0;
  logic [AW-1:0] src0_addr = '0;
  logic [AW-1:0] src1_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic          busy, done, carry_out, rd_en, wr_en, ArithRegOp, add_sub_carry;
  logic [AW-1:0] rd_addr0, rd_addr1, wr_addr;
  logic [W-1:0]  rd_data0 = '0;
  logic [W-1:0]  rd_data1 = '0;
  logic [W-1:0]  IN_REG0, IN_REG1, add_sub_out, wr_data;
  logic [1:0]    ArithOp;

  logic [W-1:0]  mem0 [256];
  logic [W-1:0]  mem1 [256];
  logic [W:0]    w_res;
  logic          r_cy = 1'b0;

  int checks = 0;
  int failures = 0;
  int unsigned cur_cycle = 0;

  mp_addsub_seq #(.CP_D_WIDTH(W), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clock(clock), .nreset(nreset), .start(start), .op_sub(op_sub), .len(len),
    .src0_addr(src0_addr), .src1_addr(src1_addr), .dst_addr(dst_addr),
    .busy(busy), .done(done), .carry_out(carry_out),
    .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .ArithOp(ArithOp), .ArithRegOp(ArithRegOp), .IN_REG0(IN_REG0), .IN_REG1(IN_REG1),
    .add_sub_out(add_sub_out), .add_sub_carry(add_sub_carry),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clock = ~clock;

  // Operand memory: data one cycle after the read strobe
  always @(posedge clock) begin
    if (rd_en) begin
      rd_data0 <= mem0[rd_addr0];
      rd_data1 <= mem1[rd_addr1];
    end
  end

  // add_sub unit: one word per cycle, carry/borrow register updates every edge
  always_comb begin
    if (ArithOp[0])
      w_res = {1'b0, IN_REG0} + {1'b0, IN_REG1} + (W+1)'(ArithOp[1] & r_cy);
    else
      w_res = {1'b0, IN_REG0} - {1'b0, IN_REG1} - (W+1)'(ArithOp[1] & r_cy);
  end
  assign add_sub_out   = w_res[W-1:0];
  assign add_sub_carry = r_cy;
  always @(posedge clock) r_cy <= w_res[W];

  initial begin
    #500000;
    $display("FAIL timeout cycle=%0d", cur_cycle);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cur_cycle, obs, exp);
    end
  endtask

  task automatic drive_cmd(input cmd_t c);
    op_sub    = c.op;
    len       = LW'(c.len);
    src0_addr = c.s0;
    src1_addr = c.s1;
    dst_addr  = c.d;
    start     = 1'b1;
  endtask

  task automatic scramble();
    op_sub    = 1'($urandom);
    len       = LW'($urandom);
    src0_addr = AW'($urandom);
    src1_addr = AW'($urandom);
    dst_addr  = AW'($urandom);
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op  = 1'($urandom);
    c.len = $urandom_range(1, MAXL);
    c.s0  = AW'($urandom);
    c.s1  = AW'($urandom);
    c.d   = AW'($urandom);
    return c;
  endfunction

  // Runs one command and checks every cycle from 1 through the done cycle.
  task automatic run_cmd(input cmd_t c, input bit pre_issued, input int unsigned pulse_at,
                         input bit chain, input cmd_t nxt);
    logic [MAXL*W:0] A, B, R;
    logic            ecy;
    int unsigned     capt;
    bit              erd, ewr;
    A = '0;
    B = '0;
    for (int unsigned w = 0; w < c.len; w++) begin
      A[w*W +: W] = mem0[(c.s0 + w) % 256];
      B[w*W +: W] = mem1[(c.s1 + w) % 256];
    end
    R    = c.op ? A - B : A + B;
    ecy  = c.op ? (A < B) : R[c.len*W];
    capt = (c.len == 0) ? 1 : c.len + 2;
    if (!pre_issued) begin
      @(negedge clock);
      drive_cmd(c);
    end
    @(posedge clock);
    for (int unsigned cyc = 1; cyc <= capt + 1; cyc++) begin
      @(negedge clock);
      cur_cycle = cyc;
      start = 1'b0;
      scramble();
      if (cyc == pulse_at) start = 1'b1;
      erd = (c.len > 0) && (cyc <= c.len);
      ewr = (c.len > 0) && (cyc >= 2) && (cyc <= c.len + 1);
      chk("busy", W'(busy), W'(cyc <= capt));
      chk("done", W'(done), W'(cyc == capt + 1));
      chk("rd_en", W'(rd_en), W'(erd));
      chk("wr_en", W'(wr_en), W'(ewr));
      if (erd) begin
        chk("rd_addr0", W'(rd_addr0), W'(AW'(c.s0 + cyc - 1)));
        chk("rd_addr1", W'(rd_addr1), W'(AW'(c.s1 + cyc - 1)));
      end
      if (ewr) begin
        chk("wr_addr", W'(wr_addr), W'(AW'(c.d + cyc - 2)));
        chk("wr_data", wr_data, R[(cyc-2)*W +: W]);
        chk("ArithOp", W'(ArithOp), W'({(cyc > 2), ~c.op}));
      end else begin
        chk("ArithOp_idle", W'(ArithOp), '0);
      end
      if (cyc == capt + 1) begin
        chk("carry_out", W'(carry_out), W'(ecy));
        if (chain) drive_cmd(nxt);
      end
    end
  endtask

  initial begin
    cmd_t c, c2, none;
    logic [W-1:0] ones;
    ones = '1;
    none = '{op: 1'b0, len: 0, s0: '0, s1: '0, d: '0};
    for (int i = 0; i < 256; i++) begin
      mem0[i] = W'({$urandom(), $urandom(), $urandom()});
      mem1[i] = W'({$urandom(), $urandom(), $urandom()});
    end

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_carry", W'(carry_out), '0);
    chk("rst_rd_en", W'(rd_en), '0);
    chk("rst_wr_en", W'(wr_en), '0);
    chk("rst_addr", W'({rd_addr0, rd_addr1, wr_addr}), '0);
    chk("rst_arith", W'({ArithOp, ArithRegOp}), '0);
    nreset = 1'b1;
    @(negedge clock);

    // Add across three words: carry ripples through all-ones words
    mem0[10] = ones; mem0[11] = ones; mem0[12] = '0;
    mem1[20] = W'(1); mem1[21] = '0;  mem1[22] = W'(5);
    run_cmd('{op: 1'b0, len: 3, s0: 8'd10, s1: 8'd20, d: 8'd30}, 0, 0, 0, none);

    // Subtract with borrow out of the top word
    mem0[40] = '0;   mem0[41] = '0;
    mem1[50] = W'(1); mem1[51] = '0;
    run_cmd('{op: 1'b1, len: 2, s0: 8'd40, s1: 8'd50, d: 8'd60}, 0, 0, 0, none);

    // Zero length: no traffic, carry forced to 0 after a borrow of 1
    run_cmd('{op: 1'b0, len: 0, s0: 8'd1, s1: 8'd2, d: 8'd3}, 0, 0, 0, none);

    // Single word overflow
    mem0[70] = ones; mem1[71] = W'(1);
    run_cmd('{op: 1'b0, len: 1, s0: 8'd70, s1: 8'd71, d: 8'd72}, 0, 0, 0, none);

    // Address wrap on all three streams
    run_cmd('{op: 1'b0, len: 3, s0: 8'hFE, s1: 8'hFD, d: 8'hFF}, 0, 0, 0, none);

    // Start pulsed mid-run is ignored; next command issued in the done cycle
    c  = '{op: 1'b0, len: 6, s0: 8'd100, s1: 8'd120, d: 8'd140};
    c2 = '{op: 1'b1, len: 4, s0: 8'd160, s1: 8'd170, d: 8'd180};
    run_cmd(c, 0, 3, 1, c2);
    run_cmd(c2, 1, 0, 0, none);

    // Randomised commands
    for (int k = 0; k < 8; k++) begin
      c = rand_cmd();
      run_cmd(c, 0, 0, 0, none);
    end

    // Reset in RUN cycle 2 of a 5-word add
    @(negedge clock);
    drive_cmd('{op: 1'b0, len: 5, s0: 8'd5, s1: 8'd6, d: 8'd7});
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    chk("pre_rst_rd_en", W'(rd_en), W'(1));
    @(negedge clock);
    nreset = 1'b0;
    #1;
    chk("arst_busy", W'(busy), '0);
    chk("arst_done", W'(done), '0);
    chk("arst_carry", W'(carry_out), '0);
    chk("arst_rd_en", W'(rd_en), '0);
    chk("arst_wr_en", W'(wr_en), '0);
    chk("arst_addr", W'({rd_addr0, rd_addr1, wr_addr}), '0);
    chk("arst_arith", W'(ArithOp), '0);
    repeat (3) begin
      @(negedge clock);
      chk("in_rst_wr_en", W'(wr_en), '0);
    end
    nreset = 1'b1;
    repeat (10) begin
      @(negedge clock);
      chk("post_rst_quiet", W'({done, wr_en, rd_en, busy}), '0);
    end

    // Normal operation after the abort
    c = rand_cmd();
    run_cmd(c, 0, 0, 0, none);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mp_addsub_seq.md
Name: mp_addsub_seq

Overview:
- Sequencer that drives the CP cluster add/sub datapath through multi-word (multi-precision) addition and subtraction.
- Streams operand words, LSW first, from the CP operand memory read port into the adder, and writes each result word back.
- Chains the carry or borrow word-to-word and returns the final carry/borrow to the CP controller.
- Sits between the controller (start/done handshake), the operand memory, and the add_sub unit (ArithOp/ArithRegOp/IN_REG0/IN_REG1 in; add_sub_out/add_sub_carry back).

Parameters:
CP_D_WIDTH, 72, datapath word width
ADDR_W, 8, operand memory address width
LEN_W, 8, word-count field width

Ports:
clock  in  1  clock
nreset  in  1  asynchronous active-low reset
start  in  1  command strobe, sampled in IDLE only
op_sub  in  1  1 = subtract (src0 - src1), 0 = add
len  in  LEN_W  number of words
src0_addr  in  ADDR_W  base address of operand A
src1_addr  in  ADDR_W  base address of operand B
dst_addr  in  ADDR_W  base address of result
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse
carry_out  out  1  final carry (add) or borrow (sub); held until next accepted start
rd_en  out  1  operand read strobe
rd_addr0  out  ADDR_W  operand A read address
rd_addr1  out  ADDR_W  operand B read address
rd_data0  in  CP_D_WIDTH  operand A data; valid exactly 1 cycle after rd_en
rd_data1  in  CP_D_WIDTH  operand B data; valid exactly 1 cycle after rd_en
ArithOp  out  2  to add_sub: bit0 = 1 add / 0 sub; bit1 = use stored carry
ArithRegOp  out  1  to add_sub: tied 0
IN_REG0  out  CP_D_WIDTH  equals rd_data0 (combinational pass-through)
IN_REG1  out  CP_D_WIDTH  equals rd_data1 (combinational pass-through)
add_sub_out  in  CP_D_WIDTH  adder result word
add_sub_carry  in  1  adder carry register; updates on every clock edge
wr_en  out  1  result write strobe
wr_addr  out  ADDR_W  result address
wr_data  out  CP_D_WIDTH  equals add_sub_out

Behaviour:
- Reset (asynchronous, nreset low): state IDLE. busy, done, carry_out, rd_en and wr_en are 0. All address outputs and ArithOp are 0. Reset mid-operation aborts at once: no further reads or writes, and no done pulse.
- Accepting a command: start is accepted only in IDLE. On acceptance, len, op_sub and the three base addresses are latched. start while busy is ignored.
- States:
  - IDLE: on start with len != 0, go to RUN. On start with len == 0, go to CAPT (no reads, no writes).
  - RUN: lasts len cycles. Cycle i asserts rd_en with rd_addr0 = src0_addr+i and rd_addr1 = src1_addr+i. After the last read, go to FLUSH.
  - FLUSH: one cycle. It computes the last word; no read is issued. Then go to CAPT.
  - CAPT: one cycle. Load carry_out from add_sub_carry; load carry_out to 0 if len == 0. Set done for the next cycle. Return to IDLE.
- Compute pipeline: word i is computed in the cycle after its read, so compute overlaps the next read.
  - In the compute cycle for word i: wr_en = 1, wr_addr = dst_addr+i, wr_data = add_sub_out.
  - ArithOp[0] = ~op_sub.
  - ArithOp[1] = 0 for word 0 and 1 for every later word.
- Words stream back-to-back with no bubbles. This is mandatory because add_sub_carry updates every cycle.
- When no compute is active, ArithOp = 2'b00.
- Address arithmetic: base + i, wrapping modulo 2^ADDR_W.
- Timing: start is sampled at cycle 0. Reads occur in cycles 1..len and writes in cycles 2..len+1. CAPT is cycle len+2 and done is cycle len+3. For len = 0, done is cycle 2.
- busy is high from cycle 1 through CAPT inclusive, and low in the done cycle.
- carry_out is valid in the done cycle. A start coinciding with the done cycle is accepted.

Test Plan:
- Add, len=3, A={FF..FF, FF..FF, 0}, B={1, 0, 5} (word0 first) -> writes {0, 0, 6} at cycles 2..4; done at cycle 6; carry_out=0; ArithOp sequence 01, 11, 11.
- Sub, len=2, A={0, 0}, B={1, 0} -> writes {FF..FF, FF..FF}; ArithOp 00, 10; carry_out=1 (borrow).
- len=0 -> no rd_en, no wr_en; done at cycle 2; carry_out=0. len=1 add of FF..FF + 1 -> wr_data=0, carry_out=1.
- Address wrap: src0_addr=0xFE, len=3 -> rd_addr0 = FE, FF, 00, with writes likewise wrapped.
- start pulsed during RUN is ignored, and the result is unchanged. start in the done cycle -> the new command's reads begin the next cycle.
- nreset asserted in RUN cycle 2 of a len=5 add -> all outputs go to 0 immediately, no further wr_en, and no done pulse.
